// File: rtl/mul4_seq_scheduler.sv
// Sequential 2W x 2W -> 4W unsigned multiplier built from one shared W x W multiplier.
// Four partial products are accumulated over four cycles; the result is held until consumed.
module mul4_seq_scheduler #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b1,
  input  logic [W-1:0]     b0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     y3,
  output logic [W-1:0]     y2,
  output logic [W-1:0]     y1,
  output logic [W-1:0]     y0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [W-1:0]       a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
  logic [4*W-1:0]     acc_q, acc_d;
  logic [4*W-1:0]     y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [W-1:0]       mul_x, mul_y;
  logic [2*W-1:0]     pp;
  logic [4*W-1:0]     pp_shift;
  logic [4*W-1:0]     acc_sum;

  // Operand selection follows the step: x picks a1 on steps 2/3, y picks b1 on steps 1/3.
  always_comb begin
    mul_x = step_q[1] ? a1_q : a0_q;
    mul_y = step_q[0] ? b1_q : b0_q;
    pp    = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
    case (step_q)
      2'd0:    pp_shift = {{(2*W){1'b0}}, pp};
      2'd3:    pp_shift = {pp, {(2*W){1'b0}}};
      default: pp_shift = {{W{1'b0}}, pp, {W{1'b0}}};
    endcase
    acc_sum = acc_q + pp_shift;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    b1_d    = b1_q;
    b0_d    = b0_q;
    acc_d   = acc_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a1_d    = a1;
          a0_d    = a0;
          b1_d    = b1;
          b0_d    = b0;
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          y_d     = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a1_q    <= '0;
      a0_q    <= '0;
      b1_q    <= '0;
      b0_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      b1_q    <= b1_d;
      b0_q    <= b0_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y3        = y_q[4*W-1:3*W];
  assign y2        = y_q[3*W-1:2*W];
  assign y1        = y_q[2*W-1:W];
  assign y0        = y_q[W-1:0];
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_mul4_seq_scheduler.sv
// Bench for mul4_seq_scheduler: directed product table, backpressure, abort, random and wrap runs
// checked against a plain 64-bit product and a delivered-count model.
module tb_mul4_seq_scheduler;

  localparam int W     = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [W-1:0]     a1, a0, b1, b0;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     y3, y2, y1, y0;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count;

  logic [4*W-1:0]   y_bus;
  assign y_bus = {y3, y2, y1, y0};

  mul4_seq_scheduler #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a1        (a1),
    .a0        (a0),
    .b1        (b1),
    .b0        (b0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y3        (y3),
    .y2        (y2),
    .y1        (y1),
    .y0        (y0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] y;
  } vec_t;

  int          n_chk;
  int          n_fail;
  int          cnt_m;
  logic [63:0] hold_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction with out_ready held high; inputs are scrambled after the accept edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int edges;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    {a1, a0}  = a;
    {b1, b0}  = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    {a1, a0} = $urandom;
    {b1, b0} = $urandom;
    chk("y_hold_in_mul", y_bus, hold_y);
    chk("in_ready_mul", 64'(in_ready), 64'd0);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
      if (edges == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("latency", 64'(edges), 64'd4);
    chk("product", y_bus, exp);
    hold_y = exp;
    @(negedge clk);
    cnt_m = (cnt_m + 1) % (1 << CNT_W);
    chk("out_valid_after", 64'(out_valid), 64'd0);
    chk("op_count", 64'(op_count), 64'(cnt_m));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [31:0] ra, rb;
    logic [63:0] exp;
    int          edges;
    logic        seen_valid;

    n_chk = 0; n_fail = 0; cnt_m = 0; hold_y = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a1 = '0; a0 = '0; b1 = '0; b0 = '0;

    vt[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vt[2] = '{32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008};
    vt[3] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vt[4] = '{32'hFFFF_0000, 32'h0000_FFFF, 64'h0000_FFFE_0001_0000};
    vt[5] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};

    #1;
    chk("rst_y", y_bus, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_op_count", 64'(op_count), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vt[i].a, vt[i].b, vt[i].y);

    // Backpressure: result held in DONE while new operands are offered.
    @(negedge clk);
    ra = 32'h1234_5678; rb = 32'h9ABC_DEF0;
    exp = 64'(ra) * 64'(rb);
    {a1, a0} = ra; {b1, b0} = rb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk("bp_latency", 64'(edges), 64'd4);
    chk("bp_product", y_bus, exp);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      {a1, a0} = $urandom;
      {b1, b0} = $urandom;
      @(negedge clk);
      chk("bp_y_stable", y_bus, exp);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_op_count", 64'(op_count), 64'(cnt_m));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cnt_m = (cnt_m + 1) % (1 << CNT_W);
    hold_y = exp;
    chk("bp_release_count", 64'(op_count), 64'(cnt_m));
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    chk("bp_no_capture", y_bus, exp);

    // Abort: reset mid-cycle at step 2 of the max product.
    {a1, a0} = 32'hFFFF_FFFF; {b1, b0} = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_y", y_bus, 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_m = 0; hold_y = '0;
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_result", 64'(seen_valid), 64'd0);
    chk("abort_count_kept", 64'(op_count), 64'd0);

    // Random products; 256 of them bring the counter back to zero.
    for (int i = 0; i < 256; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 1) ra[31:16] = 16'hFFFF;
      if (i % 16 == 2) rb[15:0]  = 16'hFFFF;
      if (i % 16 == 3) ra = 32'd0;
      run_op(ra, rb, 64'(ra) * 64'(rb));
    end
    chk("wrap_op_count", 64'(op_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
